// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if: instruction-memory and decode handshake bundle         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_target;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
             redirect, redirect_target
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
             redirect, redirect_target
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit: pipelined instruction fetch with buffer and redirect flush|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   localparam int unsigned PTR_W     = (DEPTH > 2) ? 2 : 1;
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   state_e           state_q,    state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] discard_q,  discard_d;
   logic [CNT_W-1:0] count_q,    count_d;
   logic [PTR_W-1:0] head_q,     head_d;
   logic [PTR_W-1:0] tail_q,     tail_d;
   logic [31:0]      buf_instr_q [DEPTH];
   logic [31:0]      buf_instr_d [DEPTH];
   logic [31:0]      buf_pc_q    [DEPTH];
   logic [31:0]      buf_pc_d    [DEPTH];

   logic [CNT_W:0]   occupancy_sum;
   logic [31:0]      rsp_pc;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_fire;
   logic             pop_fire;

   assign occupancy_sum = {1'b0, inflight_q} + {1'b0, count_q};
   assign req_valid     = rst_n && (state_q == ST_FETCH) && !bus.redirect &&
                          (occupancy_sum < (CNT_W+1)'(DEPTH));
   assign req_fire      = req_valid && bus.imem_req_ready;
   assign rsp_fire      = bus.imem_rsp_valid;
   assign pop_fire      = (count_q != '0) && bus.instr_ready;

   // In FETCH every outstanding request is live and consecutive, so the
   // oldest one sits inflight words behind fetch_pc.
   assign rsp_pc = fetch_pc_q - 32'({inflight_q, 2'b00});

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      inflight_d  = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      discard_d   = discard_q;
      count_d     = count_q;
      head_d      = head_q;
      tail_d      = tail_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;

      if (bus.redirect) begin
         fetch_pc_d = {bus.redirect_target[31:2], 2'b00};
         discard_d  = inflight_q - CNT_W'(rsp_fire);
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         state_d    = (discard_d != '0) ? ST_FLUSH : ST_FETCH;
      end else if (state_q == ST_FLUSH) begin
         if (rsp_fire) begin
            discard_d = discard_q - CNT_W'(1);
            if (discard_d == '0) begin
               state_d = ST_FETCH;
            end
         end
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rsp_fire) begin
            buf_instr_d[tail_q] = bus.imem_rsp_data;
            buf_pc_d[tail_q]    = rsp_pc;
            tail_d              = tail_q + PTR_W'(1);
         end
         if (pop_fire) begin
            head_d = head_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(rsp_fire) - CNT_W'(pop_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            buf_instr_q[i] <= NOP_INSTR;
            buf_pc_q[i]    <= RESET_PC;
         end
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         inflight_q  <= inflight_d;
         discard_q   <= discard_d;
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.instr_valid    = (count_q != '0);
   assign bus.instr          = buf_instr_q[head_q];
   assign bus.instr_pc       = buf_pc_q[head_q];
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit: scoreboard bench for fetch_unit (DEPTH 2 and DEPTH 4)  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
   localparam int          HALF = 5;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;
   typedef struct { logic [31:0] target; logic [31:0] first; logic [31:0] second; } redir_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #HALF clk = ~clk;

   fetch_unit_if bus_a ();
   fetch_unit_if bus_b ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   pend_t       pend_a[$];
   pend_t       pend_b[$];
   exp_t        exp_a[$];
   exp_t        exp_b[$];
   int          cyc      = 0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat_a    = 1;
   logic [31:0] model_pc = 32'h0;
   int          acc_cnt  = 0;
   logic [31:0] last_acc = 32'h0;
   int          b_acc_n  = 0;
   int          b_pop_n  = 0;
   logic [31:0] b_acc_addr [3];
   int          b_acc_cyc  [3];
   logic [31:0] b_pop_pc   [3];

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'hC0DE_0000;
   endfunction

   function automatic int stale_cnt_a();
      int n = 0;
      foreach (pend_a[i]) if (pend_a[i].stale) n++;
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic wait_acc(input int target, input string name);
      for (int t = 0; t < 40 && acc_cnt < target; t++) @(negedge clk);
      n_checks++;
      if (acc_cnt < target) begin
         n_fail++;
         $display("FAIL %s: request count %0d, expected %0d", name, acc_cnt, target);
      end
   endtask

   // Memory model: in-order responses, each due lat cycles after acceptance.
   always @(negedge clk) begin
      if (pend_a.size() != 0 && pend_a[0].due <= cyc) begin
         bus_a.imem_rsp_valid = 1'b1;
         bus_a.imem_rsp_data  = mem_word(pend_a[0].addr);
      end else begin
         bus_a.imem_rsp_valid = 1'b0;
         bus_a.imem_rsp_data  = 32'h0;
      end
      if (pend_b.size() != 0 && pend_b[0].due <= cyc) begin
         bus_b.imem_rsp_valid = 1'b1;
         bus_b.imem_rsp_data  = mem_word(pend_b[0].addr);
      end else begin
         bus_b.imem_rsp_valid = 1'b0;
         bus_b.imem_rsp_data  = 32'h0;
      end
   end

   task automatic sample_a();
      logic  exp_rv;
      pend_t p;
      exp_t  e;
      if (!rst_n) begin
         pend_a.delete();
         exp_a.delete();
         model_pc = 32'h0;
         return;
      end
      exp_rv = !bus_a.redirect && (stale_cnt_a() == 0) && (pend_a.size() + exp_a.size() < 2);
      check("a_req_valid", 32'(bus_a.imem_req_valid), 32'(exp_rv));
      if (bus_a.imem_req_valid) check("a_req_addr", bus_a.imem_req_addr, model_pc);
      check("a_instr_valid", 32'(bus_a.instr_valid), 32'(exp_a.size() != 0));
      if (bus_a.instr_valid && exp_a.size() != 0) begin
         check("a_instr", bus_a.instr, exp_a[0].data);
         check("a_instr_pc", bus_a.instr_pc, exp_a[0].pc);
      end
      if (bus_a.redirect) begin
         foreach (pend_a[i]) pend_a[i].stale = 1'b1;
         exp_a.delete();
         model_pc = {bus_a.redirect_target[31:2], 2'b00};
      end else if (bus_a.instr_valid && bus_a.instr_ready && exp_a.size() != 0) begin
         e = exp_a.pop_front();
      end
      if (bus_a.imem_rsp_valid && pend_a.size() != 0) begin
         p = pend_a.pop_front();
         if (!p.stale) begin
            e.data = mem_word(p.addr);
            e.pc   = p.addr;
            exp_a.push_back(e);
         end
      end
      if (bus_a.imem_req_valid && bus_a.imem_req_ready) begin
         p.addr  = bus_a.imem_req_addr;
         p.due   = cyc + lat_a;
         p.stale = 1'b0;
         pend_a.push_back(p);
         acc_cnt++;
         last_acc = bus_a.imem_req_addr;
         if (!bus_a.redirect) model_pc = model_pc + 32'd4;
      end
   endtask

   task automatic sample_b();
      pend_t p;
      exp_t  e;
      if (!rst_n) begin
         pend_b.delete();
         exp_b.delete();
         return;
      end
      check("b_instr_valid", 32'(bus_b.instr_valid), 32'(exp_b.size() != 0));
      if (bus_b.instr_valid && exp_b.size() != 0) begin
         check("b_instr", bus_b.instr, exp_b[0].data);
         check("b_instr_pc", bus_b.instr_pc, exp_b[0].pc);
         if (b_pop_n < 3) begin
            b_pop_pc[b_pop_n] = bus_b.instr_pc;
            b_pop_n++;
         end
         e = exp_b.pop_front();
      end
      if (bus_b.imem_rsp_valid && pend_b.size() != 0) begin
         p      = pend_b.pop_front();
         e.data = mem_word(p.addr);
         e.pc   = p.addr;
         exp_b.push_back(e);
      end
      if (bus_b.imem_req_valid && bus_b.imem_req_ready) begin
         p.addr  = bus_b.imem_req_addr;
         p.due   = cyc + 1;
         p.stale = 1'b0;
         pend_b.push_back(p);
         if (b_acc_n < 3) begin
            b_acc_addr[b_acc_n] = bus_b.imem_req_addr;
            b_acc_cyc[b_acc_n]  = cyc;
            b_acc_n++;
         end
      end
   endtask

   // Sample one time unit before each rising edge, with inputs settled.
   always @(negedge clk) begin
      #(HALF - 1);
      sample_a();
      sample_b();
      cyc++;
   end

   initial begin
      bit     found;
      int     base;
      redir_t tbl [4];
      tbl[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
      tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
      tbl[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
      tbl[3] = '{32'h8000_0ABF, 32'h8000_0ABC, 32'h8000_0AC0};

      bus_a.imem_req_ready  = 1'b0;
      bus_a.instr_ready     = 1'b0;
      bus_a.redirect        = 1'b0;
      bus_a.redirect_target = 32'h0;
      bus_b.imem_req_ready  = 1'b1;
      bus_b.instr_ready     = 1'b1;
      bus_b.redirect        = 1'b0;
      bus_b.redirect_target = 32'h0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_a_req_valid", 32'(bus_a.imem_req_valid), 32'h0);
      check("rst_a_instr_valid", 32'(bus_a.instr_valid), 32'h0);
      check("rst_a_instr", bus_a.instr, NOP);
      check("rst_a_instr_pc", bus_a.instr_pc, 32'h0);
      check("rst_b_req_valid", 32'(bus_b.imem_req_valid), 32'h0);
      check("rst_b_instr", bus_b.instr, NOP);

      // Request held while memory stalls, then buffer fills with decode stalled.
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("a_stall_valid", 32'(bus_a.imem_req_valid), 32'h1);
      check("a_stall_addr", bus_a.imem_req_addr, 32'h0);
      bus_a.imem_req_ready = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      check("a_full_req_count", 32'(acc_cnt), 32'd2);
      check("a_full_req_valid", 32'(bus_a.imem_req_valid), 32'h0);
      check("a_full_head_pc", bus_a.instr_pc, 32'h0);
      bus_a.instr_ready = 1'b1;
      @(negedge clk) bus_a.instr_ready = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("a_refill_count", 32'(acc_cnt), 32'd3);
      check("a_refill_addr", last_acc, 32'h8);

      // DEPTH=4 instance streams back-to-back from reset.
      check("b_req_logged", 32'(b_acc_n), 32'd3);
      check("b_pop_logged", 32'(b_pop_n), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("b_req_addr", b_acc_addr[i], 32'(i * 4));
         check("b_instr_pc_seq", b_pop_pc[i], 32'(i * 4));
      end
      for (int i = 1; i < 3; i++) check("b_req_cycle", 32'(b_acc_cyc[i]), 32'(b_acc_cyc[0] + i));

      // Redirects with two requests outstanding.
      bus_a.instr_ready = 1'b1;
      lat_a = 3;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         found = 1'b0;
         for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (pend_a.size() == 2 && stale_cnt_a() == 0) found = 1'b1;
         end
         check("redir_setup", 32'(found), 32'h1);
         bus_a.redirect        = 1'b1;
         bus_a.redirect_target = tbl[k].target;
         @(negedge clk) bus_a.redirect = 1'b0;
         base = acc_cnt;
         wait_acc(base + 1, "redir_first_wait");
         check("redir_first_addr", last_acc, tbl[k].first);
         wait_acc(base + 2, "redir_second_wait");
         check("redir_second_addr", last_acc, tbl[k].second);
      end

      // Redirect coinciding with a response and a head pop.
      lat_a = 1;
      bus_a.instr_ready = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge clk);
         #1;
         if (exp_a.size() >= 1 && bus_a.imem_rsp_valid) found = 1'b1;
      end
      check("coincide_setup", 32'(found), 32'h1);
      bus_a.redirect        = 1'b1;
      bus_a.redirect_target = 32'h0000_0200;
      bus_a.instr_ready     = 1'b1;
      @(negedge clk) bus_a.redirect = 1'b0;
      #1;
      check("coincide_instr_valid", 32'(bus_a.instr_valid), 32'h0);
      base = acc_cnt;
      wait_acc(base + 1, "coincide_wait");
      check("coincide_addr", last_acc, 32'h0000_0200);

      // Asynchronous reset in the middle of traffic.
      lat_a = 2;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_req_valid", 32'(bus_a.imem_req_valid), 32'h0);
      check("mid_rst_instr_valid", 32'(bus_a.instr_valid), 32'h0);
      check("mid_rst_instr", bus_a.instr, NOP);
      check("mid_rst_instr_pc", bus_a.instr_pc, 32'h0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      base = acc_cnt;
      wait_acc(base + 1, "post_rst_wait");
      check("post_rst_addr", last_acc, 32'h0);
      repeat (10) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
